iomem_gpio: RTL and testbench
=============================

// Module: iomem_gpio
// PURPOSE
//  Parametrised GPIO peripheral on the PicoSoC iomem bus; successor to the fixed 4-bit LED/switch port.
//  Adds per-pin direction, synchronised inputs, per-pin edge interrupts (selectable polarity) and a
//  multi-register map. Sits beside picosoc_noflash; irq drives one of irq_5..irq_7.
// PARAMETERS
//  BASE_ADDR    8'h03  select when iomem_addr[31:24]==BASE_ADDR
//  WIDTH        32     pin count, 1..32; register bits >= WIDTH ignore writes, read 0
//  SYNC_STAGES  2      input synchroniser depth, >= 2
// PORTS
//  clk          in   1      system clock
//  resetn       in   1      synchronous, active-low reset
//  iomem_valid  in   1      bus request
//  iomem_ready  out  1      one-cycle acknowledge
//  iomem_wstrb  in   4      byte write strobes; 4'b0000 = read
//  iomem_addr   in   32     byte address; [4:2] = register index
//  iomem_wdata  in   32     write data
//  iomem_rdata  out  32     read data, valid while iomem_ready=1
//  gpio_in      in   WIDTH  asynchronous pin inputs
//  gpio_out     out  WIDTH  DATA_OUT register
//  gpio_oe      out  WIDTH  DIR register, 1 = drive pin
//  irq          out  1      level interrupt, registered
// BEHAVIOUR
//  Registers (index = addr[4:2]): 0 DATA_OUT RW; 1 DIR RW; 2 DATA_IN RO (synchronised pins);
//   3 IRQ_EN RW; 4 IRQ_STAT W1C; 5 IRQ_POL RW (0 rising, 1 falling); 6,7 read 0, writes ignored.
//  Reset: all registers, sync chain, iomem_ready, iomem_rdata, irq = 0; all pins inputs (gpio_oe=0).
//  Reset asserted mid-transaction: ready stays 0, no write commits.
//  Handshake: sel = valid & !ready & addr[31:24]==BASE_ADDR. Cycle after sel: ready=1 for exactly 1 cycle,
//   rdata registered in the same edge. Held valid yields one ack per two cycles (never back-to-back).
//   Unselected address: no response, rdata unchanged. Writes to RO/unused indices acked, no effect.
//  Writes: byte lane n updates bits [8n+7:8n] only when wstrb[n]=1; write takes effect at the ack edge.
//   Reads return pre-write contents of the addressed register.
//  Inputs: SYNC_STAGES flop chain; DATA_IN lags gpio_in by SYNC_STAGES cycles. prev = last synced value.
//  Arming: counter holds edge detection off for SYNC_STAGES+1 cycles after reset; no events while unarmed.
//  Event[i] = armed & (POL[i] ? prev[i]&!sync[i] : !prev[i]&sync[i]); sets IRQ_STAT[i] next edge,
//   regardless of IRQ_EN. W1C: a 1 in wdata (strobed lane) clears the bit; 0 leaves it.
//  Simultaneous W1C and event on the same bit: set wins (bit stays 1).
//  POL change mid-run does not itself create an event; only transitions of sync are evaluated.
//  irq = registered |(IRQ_STAT & IRQ_EN): asserts 1 cycle after status bit sets; clears 1 cycle after W1C.
// TESTING
//  1 DIR=0xFF then write 0x000000A5 to DATA_OUT, wstrb=0001 -> gpio_out[7:0]=0xA5, gpio_oe[7:0]=0xFF,
//    ready high exactly 1 cycle, 1 cycle after valid.
//  2 DATA_OUT=0, write 0x12345678 wstrb=0100 -> read DATA_OUT = 0x00340000; WIDTH=8 build reads 0x00000000.
//  3 IRQ_EN=0x8, POL=0, gpio_in[3] 0->1 -> DATA_IN bit3 after 2 cycles, IRQ_STAT=0x8, irq=1;
//    write IRQ_STAT=0x8 -> irq=0 one cycle after ack; write 0x0 leaves it set.
//  4 POL[0]=1, W1C of bit0 on same edge as a new falling event on pin0 -> IRQ_STAT[0] stays 1.
//  5 addr 0x04000000 -> no ready; addr 0x0300001C read -> ready, rdata=0; held valid -> ack every 2nd cycle.
//  6 gpio_in=all 1s through reset, POL=0 -> no IRQ_STAT bits set; resetn low during ack -> ready 0, no write.

Source files
------------

// File: rtl/iomem_gpio.sv
// GPIO peripheral for the PicoSoC iomem bus: per-pin direction, synchronised inputs and
// per-pin edge interrupts with selectable polarity.
module iomem_gpio #(
  parameter logic [7:0]  BASE_ADDR   = 8'h03,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int unsigned    CntW     = $clog2(SYNC_STAGES + 2);
  localparam logic [CntW-1:0] ArmCount = CntW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out_q, dir_q, irq_en_q, irq_stat_q, irq_pol_q, prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CntW-1:0]  arm_cnt_q;

  logic             sel, do_write, armed, unused_bits;
  logic [2:0]       idx;
  logic [31:0]      wmask, rd_val;
  logic [WIDTH-1:0] wr_mask, wr_data, sync_val, event_v, stat_d;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    zext = '0;
    zext[WIDTH-1:0] = v;
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] new_v,
                                             input logic [WIDTH-1:0] mask);
    merge = (old_v & ~mask) | (new_v & mask);
  endfunction

  assign sel      = iomem_valid & ~iomem_ready & (iomem_addr[31:24] == BASE_ADDR);
  assign do_write = sel & (|iomem_wstrb);
  assign idx      = iomem_addr[4:2];
  assign wmask    = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wr_mask  = wmask[WIDTH-1:0];
  assign wr_data  = iomem_wdata[WIDTH-1:0];
  assign sync_val = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_cnt_q == ArmCount);

  // Upper data/mask bits are dropped when WIDTH < 32.
  assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, wmask};

  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0:    rd_val = zext(data_out_q);
      3'd1:    rd_val = zext(dir_q);
      3'd2:    rd_val = zext(sync_val);
      3'd3:    rd_val = zext(irq_en_q);
      3'd4:    rd_val = zext(irq_stat_q);
      3'd5:    rd_val = zext(irq_pol_q);
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    event_v = '0;
    if (armed) begin
      event_v = (irq_pol_q & prev_q & ~sync_val) | (~irq_pol_q & ~prev_q & sync_val);
    end
    stat_d = irq_stat_q;
    if (do_write && idx == 3'd4) begin
      stat_d = irq_stat_q & ~(wr_data & wr_mask);
    end
    // A new event on the same edge as its W1C keeps the bit set.
    stat_d = stat_d | event_v;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      data_out_q  <= '0;
      dir_q       <= '0;
      irq_en_q    <= '0;
      irq_stat_q  <= '0;
      irq_pol_q   <= '0;
      prev_q      <= '0;
      arm_cnt_q   <= '0;
      irq         <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      iomem_ready <= sel;
      if (sel) begin
        iomem_rdata <= rd_val;
      end
      sync_q[0] <= gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_val;
      if (!armed) begin
        arm_cnt_q <= arm_cnt_q + 1'b1;
      end
      irq_stat_q <= stat_d;
      irq        <= |(irq_stat_q & irq_en_q);
      if (do_write) begin
        case (idx)
          3'd0:    data_out_q <= merge(data_out_q, wr_data, wr_mask);
          3'd1:    dir_q      <= merge(dir_q, wr_data, wr_mask);
          3'd3:    irq_en_q   <= merge(irq_en_q, wr_data, wr_mask);
          3'd5:    irq_pol_q  <= merge(irq_pol_q, wr_data, wr_mask);
          default: ;
        endcase
      end
    end
  end

  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed bench for iomem_gpio: a 32-pin instance plus an 8-pin instance sharing the bus,
// with read data checked against a queue of expected values.
module tb_iomem_gpio;

  localparam logic [31:0] ADataOut = 32'h0300_0000;
  localparam logic [31:0] ADir     = 32'h0300_0004;
  localparam logic [31:0] ADataIn  = 32'h0300_0008;
  localparam logic [31:0] AIrqEn   = 32'h0300_000C;
  localparam logic [31:0] AIrqStat = 32'h0300_0010;
  localparam logic [31:0] AIrqPol  = 32'h0300_0014;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] gpio_in = '1;
  logic        ready, irq, ready8, irq8;
  logic [31:0] rdata, rdata8, gpio_out, gpio_oe;
  logic [7:0]  out8, oe8;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  iomem_gpio dut (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  iomem_gpio #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready8),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata8),
    .gpio_in(gpio_in[7:0]), .gpio_out(out8), .gpio_oe(oe8), .irq(irq8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic xfer(input string tag, input logic [3:0] strb, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    if (strb == 4'b0000) sb.push_back(exp_rd);
    valid = 1'b1; wstrb = strb; addr = a; wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 8);
    check({tag, "_latency"}, 32'(n), 32'd1);
    if (ready && strb == 4'b0000) begin
      check({tag, "_rdata"}, rdata, sb.pop_front());
    end else if (strb == 4'b0000) begin
      void'(sb.pop_front());
    end
    valid = 1'b0; wstrb = '0;
    @(negedge clk);
    check({tag, "_ack_width"}, {31'b0, ready}, 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all pins high
    cycles(3);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_gpio_out", gpio_out, 32'd0);
    check("rst_gpio_oe", gpio_oe, 32'd0);
    resetn = 1'b1;
    cycles(8);
    xfer("arm_stat", 4'b0000, AIrqStat, '0, 32'h0);
    xfer("arm_din", 4'b0000, ADataIn, '0, 32'hFFFF_FFFF);
    gpio_in = '0;
    cycles(6);

    // 1: direction and byte-lane output write
    xfer("t1_dir", 4'b1111, ADir, 32'h0000_00FF, '0);
    xfer("t1_out", 4'b0001, ADataOut, 32'h0000_00A5, '0);
    check("t1_gpio_out", gpio_out, 32'h0000_00A5);
    check("t1_gpio_oe", gpio_oe, 32'h0000_00FF);

    // 2: single-lane write, narrow instance ignores out-of-range bits
    xfer("t2_clr", 4'b1111, ADataOut, 32'h0, '0);
    xfer("t2_wr", 4'b0100, ADataOut, 32'h1234_5678, '0);
    xfer("t2_rd", 4'b0000, ADataOut, '0, 32'h0034_0000);
    check("t2_rdata_w8", rdata8, 32'h0);

    // 3: rising-edge interrupt on pin 3
    xfer("t3_en", 4'b1111, AIrqEn, 32'h8, '0);
    xfer("t3_pol", 4'b1111, AIrqPol, 32'h0, '0);
    gpio_in[3] = 1'b1;
    cycles(1);
    xfer("t3_din_early", 4'b0000, ADataIn, '0, 32'h0);
    xfer("t3_din", 4'b0000, ADataIn, '0, 32'h8);
    check("t3_irq_set", {31'b0, irq}, 32'd1);
    xfer("t3_stat", 4'b0000, AIrqStat, '0, 32'h8);
    xfer("t3_w0", 4'b1111, AIrqStat, 32'h0, '0);
    xfer("t3_stat_kept", 4'b0000, AIrqStat, '0, 32'h8);
    check("t3_irq_kept", {31'b0, irq}, 32'd1);
    xfer("t3_w1c", 4'b1111, AIrqStat, 32'h8, '0);
    check("t3_irq_clr", {31'b0, irq}, 32'd0);
    xfer("t3_stat_clr", 4'b0000, AIrqStat, '0, 32'h0);

    // 4: falling edge on pin 0 coinciding with its W1C
    xfer("t4_pol", 4'b1111, AIrqPol, 32'h1, '0);
    gpio_in[0] = 1'b1;
    cycles(4);
    xfer("t4_rise_none", 4'b0000, AIrqStat, '0, 32'h0);
    gpio_in[0] = 1'b0;
    cycles(4);
    xfer("t4_fall", 4'b0000, AIrqStat, '0, 32'h1);
    gpio_in[0] = 1'b1;
    cycles(4);
    gpio_in[0] = 1'b0;
    cycles(2);
    xfer("t4_w1c_race", 4'b1111, AIrqStat, 32'h1, '0);
    xfer("t4_set_wins", 4'b0000, AIrqStat, '0, 32'h1);
    xfer("t4_w1c", 4'b1111, AIrqStat, 32'h1, '0);
    xfer("t4_cleared", 4'b0000, AIrqStat, '0, 32'h0);

    // 5: address decode, unused indices, held valid
    xfer("t5_dir", 4'b0000, ADir, '0, 32'h0000_00FF);
    valid = 1'b1; addr = 32'h0400_0000; wstrb = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_unsel_ready", {31'b0, ready}, 32'd0);
    end
    check("t5_unsel_rdata", rdata, 32'h0000_00FF);
    valid = 1'b0;
    @(negedge clk);
    xfer("t5_wr18", 4'b1111, 32'h0300_0018, 32'hFFFF_FFFF, '0);
    xfer("t5_rd18", 4'b0000, 32'h0300_0018, '0, 32'h0);
    xfer("t5_rd1c", 4'b0000, 32'h0300_001C, '0, 32'h0);
    repeat (3) sb.push_back(32'h0000_00FF);
    valid = 1'b1; addr = ADir; wstrb = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_held_ready", {31'b0, ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (ready && sb.size() > 0) check("t5_held_rdata", rdata, sb.pop_front());
    end
    valid = 1'b0;
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);

    // 6: reset during an ack, pins high through reset
    gpio_in = '1;
    cycles(4);
    resetn = 1'b0; valid = 1'b1; addr = ADataOut; wdata = 32'h55; wstrb = 4'b1111;
    @(negedge clk);
    check("t6_rst_ready", {31'b0, ready}, 32'd0);
    check("t6_rst_gpio_out", gpio_out, 32'd0);
    valid = 1'b0; wstrb = '0;
    @(negedge clk);
    resetn = 1'b1;
    cycles(8);
    xfer("t6_stat", 4'b0000, AIrqStat, '0, 32'h0);
    xfer("t6_out", 4'b0000, ADataOut, '0, 32'h0);
    check("t6_irq", {31'b0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
